bitstream: RTL and testbench

- Variable-length bit packer for the MJPEG entropy-coding path.
- Each cycle it accepts a right-aligned code of 0..32 bits and appends it MSB-first to a running bit stream.
- It emits a 32-bit word whenever 32 bits have accumulated.
- It reports the number of bits missing to the next byte boundary, so the caller can issue byte-alignment padding. Downstream is the byte-stuffing stage; upstream is the code multiplexer.

---
 rtl/jpeg_pkg.sv | 19 +
 rtl/bitstream.sv | 83 ++++++++
 tb/tb_bitstream.sv | 141 ++++++++++++++
 3 files changed

// File: rtl/jpeg_pkg.sv
// Shared MJPEG entropy-path constants and the low-bit mask helper,
// used by the bit packer and the byte-stuffing stage.
package jpeg_pkg;

   localparam int unsigned WORD_W = 32;
   localparam int unsigned LEN_W  = 6;
   localparam int unsigned REST_W = 3;
   localparam int unsigned CNT_W  = $clog2(WORD_W);
   localparam int unsigned STRM_W = 2 * WORD_W - 1;

   // Mask keeping the low len bits; len >= WORD_W keeps the whole word.
   function automatic logic [WORD_W-1:0] low_mask(input logic [LEN_W-1:0] len);
      if (len >= LEN_W'(WORD_W)) begin
         return '1;
      end
      return (WORD_W'(1) << len) - WORD_W'(1);
   endfunction

endpackage : jpeg_pkg

// File: rtl/bitstream.sv
// Variable-length MSB-first bit packer emitting 32-bit words.
// Optional macro BITSTREAM_LEN_CHECK_EN adds a simulation check/clamp for ilength > 32.
module bitstream
   import jpeg_pkg::*;
(
   input  logic              clk,
   input  logic              rst,
   input  logic [LEN_W-1:0]  ilength,
   input  logic [WORD_W-1:0] idata,
   output logic [REST_W-1:0] rest,
   output logic              ovalid,
   output logic [WORD_W-1:0] odata
);

   logic [WORD_W-2:0] buf_q,    buf_d;
   logic [CNT_W-1:0]  count_q,  count_d;
   logic [WORD_W-1:0] odata_q,  odata_d;
   logic              ovalid_q, ovalid_d;

   logic [LEN_W-1:0]  len_eff;
   logic [WORD_W-1:0] code_m;
   logic [LEN_W:0]    code_sh;
   logic [STRM_W-1:0] code_la;
   logic [STRM_W-1:0] stream;
   logic [LEN_W:0]    total;

`ifdef BITSTREAM_LEN_CHECK_EN
   assign len_eff = (ilength > LEN_W'(WORD_W)) ? LEN_W'(WORD_W) : ilength;

   always @(posedge clk) begin
      if (!rst && ilength > LEN_W'(WORD_W)) begin
         $error("bitstream: ilength=%0d exceeds %0d, clamped", ilength, WORD_W);
      end
   end
`else
   assign len_eff = ilength;
`endif

   // Stream is left-aligned: pending bits on top, the new code right behind them.
   always_comb begin
      code_m  = idata & low_mask(len_eff);
      code_sh = (LEN_W + 1)'(WORD_W) - (LEN_W + 1)'(len_eff);
      code_la = {code_m, (WORD_W - 1)'(0)} << code_sh;
      stream  = {buf_q, WORD_W'(0)} | (code_la >> count_q);
      total   = (LEN_W + 1)'(count_q) + (LEN_W + 1)'(len_eff);
   end

   always_comb begin
      buf_d    = buf_q;
      count_d  = count_q;
      odata_d  = odata_q;
      ovalid_d = 1'b0;
      if (total >= (LEN_W + 1)'(WORD_W)) begin
         ovalid_d = 1'b1;
         odata_d  = stream[STRM_W-1 -: WORD_W];
         buf_d    = stream[WORD_W-2:0];
         count_d  = CNT_W'(total - (LEN_W + 1)'(WORD_W));
      end else begin
         buf_d    = stream[STRM_W-1 -: (WORD_W - 1)];
         count_d  = CNT_W'(total);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         buf_q    <= '0;
         count_q  <= '0;
         odata_q  <= '0;
         ovalid_q <= 1'b0;
      end else begin
         buf_q    <= buf_d;
         count_q  <= count_d;
         odata_q  <= odata_d;
         ovalid_q <= ovalid_d;
      end
   end

   // Padding to the next byte boundary, from bits already clocked in.
   assign rest   = REST_W'(4'd8 - {1'b0, count_q[2:0]});
   assign ovalid = ovalid_q;
   assign odata  = odata_q;

endmodule : bitstream

// File: tb/tb_bitstream.sv
// Scoreboard bench for bitstream: a bit-queue reference model predicts words and padding.
module tb_bitstream;
   import jpeg_pkg::*;

   logic              clk = 1'b0;
   logic              rst;
   logic [LEN_W-1:0]  ilength;
   logic [WORD_W-1:0] idata;
   logic [REST_W-1:0] rest;
   logic              ovalid;
   logic [WORD_W-1:0] odata;

   bitstream dut (
      .clk     (clk),
      .rst     (rst),
      .ilength (ilength),
      .idata   (idata),
      .rest    (rest),
      .ovalid  (ovalid),
      .odata   (odata)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   bit          model_q[$];
   logic [31:0] exp_q[$];
   logic [31:0] last_word = '0;
   bit          mon_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [31:0] model_rest();
      return 32'((8 - (model_q.size() % 8)) % 8);
   endfunction

   // Drive one code for one cycle with random garbage above the valid bits.
   task automatic send(input int len, input logic [31:0] d);
      logic [31:0] mask;
      logic [31:0] w;
      mask = (len >= 32) ? 32'hFFFF_FFFF : ((32'd1 << len) - 32'd1);
      @(negedge clk);
      ilength = LEN_W'(len);
      idata   = (d & mask) | ($urandom & ~mask);
      @(posedge clk);
      #1;
      ilength = '0;
      for (int i = len - 1; i >= 0; i--) model_q.push_back(d[i]);
      if (model_q.size() >= 32) begin
         for (int i = 31; i >= 0; i--) w[i] = model_q.pop_front();
         exp_q.push_back(w);
      end
   endtask

   // Monitor: every cycle, ovalid must match a pending expected word, odata must match or hold.
   always @(negedge clk) begin
      if (mon_en && !rst) begin
         chk("ovalid", 32'(ovalid), 32'(exp_q.size() != 0));
         if (ovalid && exp_q.size() != 0) begin
            last_word = exp_q.pop_front();
            chk("odata", odata, last_word);
         end else if (!ovalid) begin
            chk("odata_hold", odata, last_word);
         end
         chk("rest", 32'(rest), model_rest());
      end
   end

   initial begin
      rst = 1'b1;
      ilength = '0;
      idata = '0;
      #12;
      chk("reset_ovalid", 32'(ovalid), 32'd0);
      chk("reset_odata", odata, 32'd0);
      chk("reset_rest", 32'(rest), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      mon_en = 1'b1;

      send(8, 32'hAB); send(8, 32'hCD); send(8, 32'hEF); send(8, 32'h12);
      chk("word_abcdef12", odata, 32'hABCDEF12);
      chk("abcdef12_ovalid", 32'(ovalid), 32'd1);
      chk("abcdef12_rest", 32'(rest), 32'd0);

      send(3, 32'h5);
      chk("rest_after_3", 32'(rest), 32'd5);
      send(5, 32'h1F); send(24, 32'h0);
      chk("word_bf000000", odata, 32'hBF000000);

      send(20, 32'hFFFFF); send(20, 32'h0);
      chk("word_fffff000", odata, 32'hFFFFF000);
      chk("rest_after_40", 32'(rest), 32'd0);
      send(24, 32'h0);

      send(31, 32'h7FFF_FFFF); send(32, 32'h1);
      chk("word_fffffffe", odata, 32'hFFFFFFFE);
      chk("rest_count31", 32'(rest), 32'd1);
      send(1, 32'h0);
      chk("word_pending31", odata, 32'h0000_0002);

      send(12, 32'hABC);
      #2;
      rst = 1'b1;
      #1;
      chk("async_ovalid", 32'(ovalid), 32'd0);
      chk("async_odata", odata, 32'd0);
      chk("async_rest", 32'(rest), 32'd0);
      model_q.delete();
      exp_q.delete();
      last_word = '0;
      @(negedge clk);
      #1;
      rst = 1'b0;
      send(32, 32'h12345678);
      chk("word_12345678", odata, 32'h12345678);

      send(5, 32'h3);
      for (int i = 0; i < 10; i++) send(0, $urandom);
      chk("idle_rest", 32'(rest), 32'd3);

      for (int i = 0; i < 3000; i++) begin
         int len;
         len = ($urandom_range(0, 3) == 0) ? 32 : int'($urandom_range(0, 32));
         send(len, $urandom);
      end
      repeat (3) @(negedge clk);
      chk("queue_drained", 32'(exp_q.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule : tb_bitstream
